// File: rtl/des_key_schedule_pkg.sv
// Shared constants, permutation tables and rotate helpers for the DES key schedule.
package des_pkg;
    localparam int KEY_W      = 64;
    localparam int SUBKEY_W   = 48;
    localparam int HALF_W     = 28;
    localparam int CD_W       = 2 * HALF_W;
    localparam int NUM_ROUNDS = 16;
    localparam int IDX_W      = $clog2(NUM_ROUNDS);

    typedef enum logic {IDLE, GEN} state_t;

    // DES 1-based bit indices; DES bit 1 is the MSB of each vector.
    localparam int PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFTS [NUM_ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input int n);
        return (n == 2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input int n);
        return (n == 2) ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
    endfunction
endpackage

// File: rtl/des_key_schedule_if.sv
// Key-in / subkey-out handshake bundle for the DES key schedule.
interface des_key_schedule_if;
    logic                              key_valid;
    logic                              key_ready;
    logic [des_pkg::KEY_W-1:0]         key;
    logic                              decrypt;
    logic                              sk_valid;
    logic                              sk_ready;
    logic [des_pkg::SUBKEY_W-1:0]      subkey;
    logic [des_pkg::IDX_W-1:0]         round_idx;
    logic                              busy;
    logic                              done;

    modport slave (
        input  key_valid, key, decrypt, sk_ready,
        output key_ready, sk_valid, subkey, round_idx, busy, done
    );

    modport master (
        output key_valid, key, decrypt, sk_ready,
        input  key_ready, sk_valid, subkey, round_idx, busy, done
    );
endinterface

// File: rtl/des_key_schedule_pc2.sv
// Combinational PC-2: selects 48 of the 56 C/D bits, DES bit 1 at the MSB.
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0]     cd,
    output logic [SUBKEY_W-1:0] subkey
);
    always_comb begin
        subkey = '0;
        for (int j = 0; j < SUBKEY_W; j++)
            subkey[6'(SUBKEY_W - 1 - j)] = cd[6'(CD_W - PC2[j])];
    end
endmodule

// File: rtl/des_key_schedule.sv
// DES round-key generator: one PC-2 subkey per valid/ready beat, encrypt or decrypt order.
module des_key_schedule
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    des_key_schedule_if.slave bus
);
    state_t                state;
    logic                  mode;
    logic [HALF_W-1:0]     c, d;
    logic [CD_W-1:0]       pc1_cd, cd_nxt;
    logic [SUBKEY_W-1:0]   pc2_out;
    logic [IDX_W-1:0]      idx_inc;
    logic                  last;

    assign idx_inc = bus.round_idx + IDX_W'(1);
    assign last    = mode ? (bus.round_idx == '0) : (bus.round_idx == IDX_W'(NUM_ROUNDS - 1));

    // Next C/D: PC-1 (+ first shift for encrypt) on accept, otherwise one step
    // forward or backward. Decrypt starts at C0D0 since C16D16 == C0D0.
    always_comb begin
        pc1_cd = '0;
        for (int i = 0; i < CD_W; i++)
            pc1_cd[6'(CD_W - 1 - i)] = bus.key[6'(KEY_W - PC1[i])];

        cd_nxt = {c, d};
        if (state == IDLE) begin
            if (bus.decrypt)
                cd_nxt = pc1_cd;
            else
                cd_nxt = {rotl(pc1_cd[CD_W-1:HALF_W], SHIFTS[0]), rotl(pc1_cd[HALF_W-1:0], SHIFTS[0])};
        end else if (mode) begin
            cd_nxt = {rotr(c, SHIFTS[bus.round_idx]), rotr(d, SHIFTS[bus.round_idx])};
        end else begin
            cd_nxt = {rotl(c, SHIFTS[idx_inc]), rotl(d, SHIFTS[idx_inc])};
        end
    end

    des_pc2 u_pc2 (.cd(cd_nxt), .subkey(pc2_out));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode          <= 1'b0;
            c             <= '0;
            d             <= '0;
            bus.key_ready <= 1'b0;
            bus.sk_valid  <= 1'b0;
            bus.subkey    <= '0;
            bus.round_idx <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.key_valid && bus.key_ready) begin
                        {c, d}        <= cd_nxt;
                        bus.subkey    <= pc2_out;
                        bus.round_idx <= bus.decrypt ? IDX_W'(NUM_ROUNDS - 1) : '0;
                        mode          <= bus.decrypt;
                        bus.key_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        bus.sk_valid  <= 1'b1;
                        state         <= GEN;
                    end else begin
                        bus.key_ready <= 1'b1;
                    end
                end
                GEN: begin
                    if (bus.sk_valid && bus.sk_ready) begin
                        if (last) begin
                            bus.sk_valid <= 1'b0;
                            bus.busy     <= 1'b0;
                            bus.done     <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            {c, d}        <= cd_nxt;
                            bus.subkey    <= pc2_out;
                            bus.round_idx <= mode ? bus.round_idx - IDX_W'(1) : idx_inc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
